// File: rtl/serial_transmitter.sv
// Parallel-to-serial transmit stage: a one-deep holding register feeds a
// start/data/parity/stop framer clocked by an internal bit-time divider.
module serial_transmitter #(
    parameter int CLKS_PER_BIT = 16,
    parameter int STOP_BITS    = 1,
    parameter int PARITY       = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       txd,
    output logic       tx_busy
);

    localparam int DIV_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]       STOP_LAST = 3'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PAR,
        ST_STOP
    } state_t;

    state_t           state, state_nx;
    logic [DIV_W-1:0] div, div_nx;
    logic [2:0]       cnt, cnt_nx;
    logic [7:0]       shift, shift_nx;
    logic [7:0]       hold, hold_nx;
    logic             hold_full, hold_full_nx;
    logic             par_bit, par_bit_nx;
    logic             txd_nx, ready_nx, busy_nx;
    logic             wrap, load, accept;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            div       <= '0;
            cnt       <= '0;
            shift     <= '0;
            hold      <= '0;
            hold_full <= 1'b0;
            par_bit   <= 1'b0;
            txd       <= 1'b1;
            tx_ready  <= 1'b1;
            tx_busy   <= 1'b0;
        end else begin
            state     <= state_nx;
            div       <= div_nx;
            cnt       <= cnt_nx;
            shift     <= shift_nx;
            hold      <= hold_nx;
            hold_full <= hold_full_nx;
            par_bit   <= par_bit_nx;
            txd       <= txd_nx;
            tx_ready  <= ready_nx;
            tx_busy   <= busy_nx;
        end
    end

    // tx_ready mirrors !hold_full, so an accept never coincides with a load
    always_comb begin
        state_nx     = state;
        div_nx       = div;
        cnt_nx       = cnt;
        shift_nx     = shift;
        hold_nx      = hold;
        hold_full_nx = hold_full;
        par_bit_nx   = par_bit;
        load         = 1'b0;
        wrap         = (div == DIV_LAST);
        accept       = tx_valid && tx_ready;

        if (state != ST_IDLE) begin
            div_nx = wrap ? '0 : div + DIV_W'(1);
        end

        case (state)
            ST_IDLE: begin
                if (hold_full) load = 1'b1;
            end
            ST_START: begin
                if (wrap) begin
                    state_nx = ST_DATA;
                    cnt_nx   = '0;
                end
            end
            ST_DATA: begin
                if (wrap) begin
                    shift_nx = shift >> 1;
                    if (cnt == 3'd7) begin
                        cnt_nx   = '0;
                        state_nx = (PARITY != 0) ? ST_PAR : ST_STOP;
                    end else begin
                        cnt_nx = cnt + 3'd1;
                    end
                end
            end
            ST_PAR: begin
                if (wrap) begin
                    state_nx = ST_STOP;
                    cnt_nx   = '0;
                end
            end
            ST_STOP: begin
                if (wrap) begin
                    if (cnt == STOP_LAST) begin
                        cnt_nx = '0;
                        if (hold_full) load = 1'b1;
                        else           state_nx = ST_IDLE;
                    end else begin
                        cnt_nx = cnt + 3'd1;
                    end
                end
            end
            default: state_nx = ST_IDLE;
        endcase

        if (load) begin
            shift_nx     = hold;
            par_bit_nx   = (^hold) ^ (PARITY == 2);
            hold_full_nx = 1'b0;
            state_nx     = ST_START;
            div_nx       = '0;
            cnt_nx       = '0;
        end

        if (accept) begin
            hold_nx      = tx_data;
            hold_full_nx = 1'b1;
        end
    end

    // outputs are precomputed from next-state values so they leave flops
    always_comb begin
        txd_nx = 1'b1;
        case (state_nx)
            ST_IDLE:  txd_nx = 1'b1;
            ST_START: txd_nx = 1'b0;
            ST_DATA:  txd_nx = shift_nx[0];
            ST_PAR:   txd_nx = par_bit_nx;
            ST_STOP:  txd_nx = 1'b1;
            default:  txd_nx = 1'b1;
        endcase
        ready_nx = !hold_full_nx;
        busy_nx  = (state_nx != ST_IDLE) || hold_full_nx;
    end

endmodule

// File: tb/tb_serial_transmitter.sv
// Bench for serial_transmitter: three configurations against a line-level
// frame model, plus a mid-bit sampling receiver on the first instance.
module tb_serial_transmitter;

    logic       clk;
    logic       rst_n;
    logic [7:0] data [3];
    logic       vld [3];
    logic       txd_w [3];
    logic       rdy_w [3];
    logic       busy_w [3];

    int checks = 0;
    int errors = 0;

    serial_transmitter #(.CLKS_PER_BIT(4), .STOP_BITS(1), .PARITY(0)) u_tx0 (
        .clk(clk), .rst_n(rst_n), .tx_data(data[0]), .tx_valid(vld[0]),
        .tx_ready(rdy_w[0]), .txd(txd_w[0]), .tx_busy(busy_w[0]));
    serial_transmitter #(.CLKS_PER_BIT(3), .STOP_BITS(2), .PARITY(1)) u_tx1 (
        .clk(clk), .rst_n(rst_n), .tx_data(data[1]), .tx_valid(vld[1]),
        .tx_ready(rdy_w[1]), .txd(txd_w[1]), .tx_busy(busy_w[1]));
    serial_transmitter #(.CLKS_PER_BIT(5), .STOP_BITS(2), .PARITY(2)) u_tx2 (
        .clk(clk), .rst_n(rst_n), .tx_data(data[2]), .tx_valid(vld[2]),
        .tx_ready(rdy_w[2]), .txd(txd_w[2]), .tx_busy(busy_w[2]));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int cpb_cfg(input int i);
        case (i)
            0: return 4;
            1: return 3;
            default: return 5;
        endcase
    endfunction

    function automatic int stp_cfg(input int i);
        return (i == 0) ? 1 : 2;
    endfunction

    function automatic int par_cfg(input int i);
        return i;
    endfunction

    // line model: per instance, the remaining txd level for each future cycle
    logic [63:0] m_line [3];
    int          m_len [3];
    logic        m_hv [3];
    logic [7:0]  m_hd [3];
    logic        acc [3];
    logic [7:0]  exp_q [$];

    function automatic logic [63:0] frame_levels(input int i, input logic [7:0] b,
                                                 output int len);
        logic        lv [12];
        int          n;
        logic [63:0] f;
        f = '1;
        lv[0] = 1'b0;
        n = 1;
        for (int j = 0; j < 8; j++) begin
            lv[n] = b[j];
            n++;
        end
        if (par_cfg(i) != 0) begin
            lv[n] = (^b) ^ (par_cfg(i) == 2);
            n++;
        end
        for (int s = 0; s < stp_cfg(i); s++) begin
            lv[n] = 1'b1;
            n++;
        end
        len = 0;
        for (int k = 0; k < n; k++) begin
            for (int c = 0; c < cpb_cfg(i); c++) begin
                f[6'(len)] = lv[k];
                len++;
            end
        end
        return f;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge(input int i);
        logic ready_pre;
        ready_pre = !m_hv[i];
        if (m_len[i] > 0) begin
            m_line[i] = m_line[i] >> 1;
            m_len[i]--;
        end
        if (m_len[i] == 0 && m_hv[i]) begin
            m_line[i] = frame_levels(i, m_hd[i], m_len[i]);
            m_hv[i] = 1'b0;
        end
        acc[i] = vld[i] && ready_pre;
        if (acc[i]) begin
            m_hv[i] = 1'b1;
            m_hd[i] = data[i];
            if (i == 0) exp_q.push_back(data[i]);
        end
    endtask

    task automatic step();
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            if (!rst_n) begin
                m_len[i] = 0;
                m_hv[i]  = 1'b0;
                acc[i]   = 1'b0;
                if (i == 0) exp_q.delete();
            end else begin
                model_edge(i);
            end
        end
        #1;
        for (int i = 0; i < 3; i++) begin
            check_eq($sformatf("txd%0d", i), 32'(txd_w[i]),
                     32'((m_len[i] > 0) ? m_line[i][0] : 1'b1));
            check_eq($sformatf("ready%0d", i), 32'(rdy_w[i]), 32'(!m_hv[i]));
            check_eq($sformatf("busy%0d", i), 32'(busy_w[i]),
                     32'((m_len[i] > 0) || m_hv[i]));
        end
    endtask

    task automatic send(input int i, input logic [7:0] b);
        int n;
        n = 0;
        data[i] = b;
        vld[i]  = 1'b1;
        do begin
            step();
            n++;
        end while (!acc[i] && n < 500);
        if (n >= 500) check_eq("send_timeout", 32'(n), 32'(0));
        vld[i] = 1'b0;
    endtask

    task automatic wait_idle(input int i);
        int n;
        n = 0;
        while ((m_len[i] > 0 || m_hv[i]) && n < 500) begin
            step();
            n++;
        end
        if (n >= 500) check_eq("idle_timeout", 32'(n), 32'(0));
    endtask

    // mid-bit sampling receiver on instance 0 (4 clocks/bit, 8N1)
    int         dc_frames = 0;
    logic       dc_busy = 1'b0;
    int         dc_cnt = 0;
    logic [9:0] dc_bits = '0;

    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                dc_busy = 1'b0;
                dc_cnt  = 0;
            end else begin
                if (!dc_busy && txd_w[0] == 1'b0) begin
                    dc_busy = 1'b1;
                    dc_cnt  = 0;
                end
                if (dc_busy) begin
                    if (dc_cnt % 4 == 2) dc_bits[dc_cnt / 4] = txd_w[0];
                    if (dc_cnt == 38) begin
                        check_eq("loop_start", 32'(dc_bits[0]), 32'(0));
                        check_eq("loop_stop", 32'(dc_bits[9]), 32'(1));
                        if (exp_q.size() == 0)
                            check_eq("loop_pending", 32'(exp_q.size()), 32'(1));
                        else
                            check_eq("loop_data", 32'(dc_bits[8:1]), 32'(exp_q.pop_front()));
                        dc_frames++;
                        dc_busy = 1'b0;
                    end
                    dc_cnt++;
                end
            end
        end
    end

    initial begin
        logic [7:0] loop_bytes [4];
        int         frames0;
        loop_bytes[0] = 8'h00;
        loop_bytes[1] = 8'hFF;
        loop_bytes[2] = 8'h5A;
        loop_bytes[3] = 8'hC3;
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            vld[i]    = 1'b0;
            data[i]   = '0;
            m_len[i]  = 0;
            m_hv[i]   = 1'b0;
            m_line[i] = '1;
            m_hd[i]   = '0;
            acc[i]    = 1'b0;
        end

        repeat (3) step();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (100) step();

        send(0, 8'hA5);
        wait_idle(0);

        send(1, 8'h07);
        send(2, 8'h07);
        send(1, 8'h03);
        wait_idle(1);
        wait_idle(2);

        send(1, 8'h11);
        send(1, 8'h22);
        send(1, 8'h33);
        wait_idle(1);

        // asynchronous reset during data bit 3 of 0x00 with 0x5A held
        send(0, 8'h00);
        send(0, 8'h5A);
        repeat (16) step();
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("rst_async_txd", 32'(txd_w[0]), 32'(1));
        check_eq("rst_async_ready", 32'(rdy_w[0]), 32'(1));
        check_eq("rst_async_busy", 32'(busy_w[0]), 32'(0));
        repeat (3) step();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (60) step();

        frames0 = dc_frames;
        for (int k = 0; k < 4; k++) send(0, loop_bytes[k]);
        wait_idle(0);
        repeat (2) step();
        check_eq("loop_count", 32'(dc_frames - frames0), 32'(4));

        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 3; i++) begin
                vld[i]  = ($urandom_range(0, 3) == 0);
                data[i] = 8'($urandom);
            end
            step();
        end
        for (int i = 0; i < 3; i++) vld[i] = 1'b0;
        for (int i = 0; i < 3; i++) wait_idle(i);
        repeat (2) step();
        check_eq("loop_drain", 32'(exp_q.size()), 32'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_transmitter.md
Name: serial_transmitter

Overview:
Parallel-to-serial transmit stage that produces the serial line consumed by the serial receiver in the transceiver. It accepts a byte through a valid/ready handshake and buffers it in a one-deep holding register. It frames the byte as a start bit, 8 data bits LSB-first, an optional parity bit and 1–2 stop bits. Bit timing comes from an internal divider on clk, and a full holding register lets consecutive frames go out back-to-back.

Parameters:
CLKS_PER_BIT, 16, clk cycles each serial bit is held; legal range >= 2
STOP_BITS, 1, number of stop bits; legal values 1 or 2
PARITY, 0, 0 = none, 1 = even, 2 = odd; parity bit sent after data bit 7

Ports:
clk  input  1  system clock; all state updates on its rising edge
rst_n  input  1  reset, asynchronous, active-low
tx_data  input  8  byte to send; sampled only on an accepted handshake
tx_valid  input  1  tx_data is valid
tx_ready  output  1  holding register empty; byte accepted when tx_valid && tx_ready at a rising clk edge
txd  output  1  serial line; idle high, registered
tx_busy  output  1  high while a frame is in flight or the holding register is full

Behaviour:
- Reset (async, rst_n low):
  - txd=1, tx_ready=1, tx_busy=0.
  - FSM=IDLE; divider, bit counter, shift register and holding register cleared; holding register marked empty.
  - Effect is immediate, including mid-frame: line returns high at once and any in-flight or held byte is discarded.
- Handshake:
  - At edge k with tx_valid && tx_ready, tx_data is captured into the holding register; tx_ready=0 after edge k.
  - tx_data/tx_valid are ignored while tx_ready=0.
  - tx_ready returns to 1 on the edge the FSM moves the holding register into the shift register.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: txd=1. If the holding register is full at an edge: load shift register, empty the holding register, txd=0, go to START, divider=0.
  - Bit timing: every state except IDLE holds txd for exactly CLKS_PER_BIT cycles. The divider counts 0..CLKS_PER_BIT-1; the state advances when it wraps.
  - START -> DATA. Data bits are driven from shift[0]; shift right once per bit; bit counter runs 0..7.
  - After bit 7: go to PARITY if PARITY != 0, else to STOP.
  - PARITY: txd = XOR of the 8 data bits (even), or its inverse (odd).
  - STOP: txd=1 for STOP_BITS*CLKS_PER_BIT cycles.
  - At the end of STOP: if the holding register is full, load it and go directly to START with no idle cycle in between; else go to IDLE.
- Latency:
  - Byte accepted at edge k while IDLE with holding register empty: txd falls after edge k+1, and tx_ready=1 again after edge k+1.
- Frame length: (1 + 8 + (PARITY != 0) + STOP_BITS) * CLKS_PER_BIT cycles.
- Throughput: at most one byte waits (holding register) while another is shifting. A third byte is stalled by tx_ready=0.
- Simultaneous events:
  - A new byte cannot be accepted on the same edge the holding register is emptied, because tx_ready is still 0 on that edge. The earliest next accept is the following edge.
- tx_busy = (FSM != IDLE) || holding register full. Registered; it falls on the same edge the FSM enters IDLE.
- txd, tx_ready and tx_busy are driven directly from flops; no combinational path from inputs to outputs.

Test Plan:
- Reset: hold rst_n low 3 cycles, then release -> txd=1, tx_ready=1, tx_busy=0; line stays 1 with tx_valid=0 for 100 cycles.
- Single byte, CLKS_PER_BIT=4, PARITY=0, STOP_BITS=1; send 0xA5 -> txd sequence 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles. Frame is 40 cycles; txd falls after edge k+1; tx_busy drops after the stop bit.
- Parity: send 0x07 with PARITY=1 -> parity bit 1; with PARITY=2 -> parity bit 0. Send 0x03 with PARITY=1 -> parity bit 0. Frame is 44 cycles.
- Back-to-back: offer 0x11, 0x22, 0x33 with tx_valid held high -> 0x11 and 0x22 are accepted immediately, 0x33 is accepted only after 0x11's frame ends. Three contiguous frames (STOP_BITS=2: 48 cycles each) with no idle gap.
- Reset mid-frame: assert rst_n during data bit 3 of 0x00 -> txd=1 asynchronously; after release, tx_ready=1 and the held byte is not sent.
- Loopback: connect txd to the receiver's din; send 0x00, 0xFF, 0x5A, 0xC3 -> receiver reports identical rx_data, one rx_status pulse per byte.
